shift_rotate_sequencer: RTL and testbench



---
 rtl/shift_rotate_sequencer_pkg.sv | 21 ++
 rtl/shift_rotate_sequencer_if.sv | 26 ++
 rtl/shift_rotate_sequencer_shift_step.sv | 26 ++
 rtl/shift_rotate_sequencer.sv | 82 ++++++++
 tb/tb_shift_rotate_sequencer.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/shift_rotate_sequencer_pkg.sv
// Opcode and FSM encodings shared by the shift/rotate sequencer, its step
// logic and the control unit's ALU decode.
package shift_rotate_sequencer_pkg;

    localparam int OP_W = 3;

    typedef logic [OP_W-1:0] op_t;

    localparam op_t OP_SHR  = 3'b000;
    localparam op_t OP_SHRA = 3'b001;
    localparam op_t OP_SHL  = 3'b010;
    localparam op_t OP_ROR  = 3'b011;
    localparam op_t OP_ROL  = 3'b100;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/shift_rotate_sequencer_if.sv
// Request/response bundle between the control unit (master) and the
// shift/rotate sequencer (slave).
interface shift_rotate_sequencer_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
);

    logic                                        start;
    logic [shift_rotate_sequencer_pkg::OP_W-1:0] op;
    logic [WIDTH-1:0]                            value;
    logic [CNT_W-1:0]                            count;
    logic                                        busy;
    logic                                        done;
    logic [WIDTH-1:0]                            result;

    modport master (
        output start, op, value, count,
        input  busy, done, result
    );

    modport slave (
        input  start, op, value, count,
        output busy, done, result
    );

endinterface

// File: rtl/shift_rotate_sequencer_shift_step.sv
// One single-bit shift/rotate step; unknown opcodes pass the operand through
// unchanged.
module shift_step
    import shift_rotate_sequencer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] acc,
    input  op_t              op,
    output logic [WIDTH-1:0] next_acc
);

    always_comb begin
        // NOTE: default assignment first so every path drives next_acc and no latch is inferred.
        next_acc = acc;
        case (op)
            OP_SHR:  next_acc = {1'b0, acc[WIDTH-1:1]};
            OP_SHRA: next_acc = {acc[WIDTH-1], acc[WIDTH-1:1]};
            OP_SHL:  next_acc = {acc[WIDTH-2:0], 1'b0};
            OP_ROR:  next_acc = {acc[0], acc[WIDTH-1:1]};
            OP_ROL:  next_acc = {acc[WIDTH-2:0], acc[WIDTH-1]};
            default: next_acc = acc;
        endcase
    end

endmodule

// File: rtl/shift_rotate_sequencer.sv
// Multi-cycle shift/rotate controller: latches one request, applies one
// single-bit step per clock, then pulses done with the held result.
module shift_rotate_sequencer
    import shift_rotate_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input logic                    clock,
    input logic                    clear,
    shift_rotate_sequencer_if.slave bus
);

    state_e           state;
    state_e           state_next;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_step;
    logic [WIDTH-1:0] result_q;
    op_t              op_q;
    logic [CNT_W-1:0] rem;

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .acc      (acc),
        .op       (op_q),
        .next_acc (acc_step)
    );

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.start) state_next = RUN;
            RUN:     if (rem == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
        if (clear) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operands are captured only on an accepted start; later input changes are ignored.
    always_ff @(posedge clock) begin
        if (clear) begin
            acc      <= '0;
            op_q     <= OP_SHR;
            rem      <= '0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        acc  <= bus.value;
                        op_q <= bus.op;
                        rem  <= bus.count;
                    end
                end
                RUN: begin
                    if (rem == '0) begin
                        result_q <= acc;
                    end else begin
                        acc <= acc_step;
                        rem <= rem - CNT_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy   = (state != IDLE);
    assign bus.done   = (state == DONE);
    assign bus.result = result_q;

endmodule

// File: tb/tb_shift_rotate_sequencer.sv
// Self-checking bench: cycle-level reference model compared every cycle, plus
// directed requests with hand-computed results and latencies.
module tb_shift_rotate_sequencer;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    logic clock = 1'b0;
    logic clear = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    shift_rotate_sequencer_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

    shift_rotate_sequencer #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Whole-operation result computed directly from the opcode definition.
    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] v, input int n);
        logic [63:0] dbl;
        case (op)
            3'b000: return v >> n;
            3'b001: return 32'($signed(v) >>> n);
            3'b010: return v << n;
            3'b011: begin dbl = {v, v} >> n; return dbl[31:0];  end
            3'b100: begin dbl = {v, v} << n; return dbl[63:32]; end
            default: return v;
        endcase
    endfunction

    // Reference model: remembers when the current request must finish and its answer.
    bit          m_valid    = 0;
    bit          m_inflight = 0;
    bit          m_done     = 0;
    int          m_left     = 0;
    logic [31:0] m_pending  = '0;
    logic [31:0] m_result   = '0;

    always @(posedge clock) begin
        m_valid <= 1;
        if (clear) begin
            m_inflight <= 0;
            m_done     <= 0;
            m_left     <= 0;
            m_result   <= '0;
        end else if (m_done) begin
            m_done <= 0;
        end else if (m_inflight) begin
            if (m_left == 1) begin
                m_inflight <= 0;
                m_done     <= 1;
                m_result   <= m_pending;
            end
            m_left <= m_left - 1;
        end else if (bus.start) begin
            m_inflight <= 1;
            m_left     <= int'(bus.count) + 1;
            m_pending  <= ref_op(bus.op, bus.value, int'(bus.count));
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            check("cmp_busy",   32'(bus.busy), 32'(m_inflight | m_done));
            check("cmp_done",   32'(bus.done), 32'(m_done));
            check("cmp_result", bus.result,    m_result);
        end
    end

    // Issues one request; optionally pokes a second start or a clear mid-flight.
    task automatic run_req(input string name, input logic [2:0] op, input logic [31:0] v,
                           input logic [4:0] n, input int poke_at, input bit poke_clear,
                           input logic [31:0] exp_res, input int exp_edges);
        int edges       = 0;
        int busy_cycles = 0;
        bit seen        = 0;
        @(negedge clock);
        check({name, "_idle_busy"}, 32'(bus.busy), 32'd0);
        check({name, "_idle_done"}, 32'(bus.done), 32'd0);
        bus.start = 1'b1;
        bus.op    = op;
        bus.value = v;
        bus.count = n;
        for (int k = 1; k <= 40 && !seen; k++) begin
            @(negedge clock);
            if (k == 1) begin
                bus.start = 1'b0;
                bus.op    = ~op;
                bus.value = ~v;
                bus.count = ~n;
            end
            if (poke_at != 0 && k == poke_at) begin
                if (poke_clear) begin
                    clear = 1'b1;
                end else begin
                    bus.start = 1'b1;
                    bus.op    = 3'b011;
                    bus.value = 32'h0000_1234;
                    bus.count = 5'd1;
                end
            end
            if (poke_at != 0 && k == poke_at + 1) begin
                clear     = 1'b0;
                bus.start = 1'b0;
                if (poke_clear) begin
                    check({name, "_clr_busy"},   32'(bus.busy), 32'd0);
                    check({name, "_clr_result"}, bus.result,    32'd0);
                end
            end
            if (bus.done) begin
                seen  = 1;
                edges = k;
            end else if (bus.busy) begin
                busy_cycles++;
            end
        end
        check({name, "_edges"}, 32'(edges), 32'(exp_edges));
        if (exp_edges != 0) begin
            check({name, "_result"}, bus.result, exp_res);
            check({name, "_busy_cycles"}, 32'(busy_cycles), 32'(exp_edges - 1));
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op    = 3'b000;
        bus.value = '0;
        bus.count = '0;
        repeat (3) @(negedge clock);
        clear = 1'b0;
        check("reset_busy",   32'(bus.busy), 32'd0);
        check("reset_done",   32'(bus.done), 32'd0);
        check("reset_result", bus.result,    32'd0);

        run_req("ror_1",      3'b011, 32'h0000_0001, 5'd1,  0, 0, 32'h8000_0000, 3);
        run_req("shra_31",    3'b001, 32'h8000_0000, 5'd31, 0, 0, 32'hFFFF_FFFF, 33);
        run_req("shr_31",     3'b000, 32'h8000_0000, 5'd31, 0, 0, 32'h0000_0001, 33);
        run_req("rol_0",      3'b100, 32'h1234_5678, 5'd0,  0, 0, 32'h1234_5678, 2);
        run_req("illegal_3",  3'b110, 32'hA5A5_0F0F, 5'd3,  0, 0, 32'hA5A5_0F0F, 5);
        run_req("shl_poke",   3'b010, 32'hF000_000F, 5'd4,  2, 0, 32'h0000_00F0, 6);
        run_req("ror_clear",  3'b011, 32'hDEAD_BEEF, 5'd20, 5, 1, 32'h0000_0000, 0);
        run_req("rol_31",     3'b100, 32'h8000_0001, 5'd31, 0, 0, 32'hC000_0000, 33);

        @(negedge clock);
        clear     = 1'b1;
        bus.start = 1'b1;
        bus.op    = 3'b010;
        bus.value = 32'h0000_0001;
        bus.count = 5'd2;
        @(negedge clock);
        clear     = 1'b0;
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("clr_start_busy", 32'(bus.busy), 32'd0);
            @(negedge clock);
        end

        run_req("b2b_shl",    3'b010, 32'h0000_0001, 5'd5,  0, 0, 32'h0000_0020, 7);
        run_req("b2b_shra",   3'b001, 32'hF000_0000, 5'd4,  0, 0, 32'hFF00_0000, 6);
        repeat (2) @(negedge clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
